// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock generator with glitch-free start/stop.
// Optional realignment input is enabled by defining CLK_DIV_SYNC_EN.
module clk_div_gen #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    input  logic              cfg_en,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] ch_run,
    output logic [NUM_CH-1:0] clk_p,
    output logic [NUM_CH-1:0] clk_n
`ifdef CLK_DIV_SYNC_EN
    ,
    input  logic              sync_req
`endif
);

    typedef enum logic [1:0] {
        PARKED   = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF);

    logic [31:0]      ch_idx;
    logic             wr_ok;
    logic [DIV_W-1:0] wr_half;
    logic             ack_q;
    logic             ack_d;

    assign ch_idx  = 32'(cfg_ch);
    assign wr_ok   = cfg_wr && (ch_idx < 32'(NUM_CH));
    assign wr_half = (cfg_half == '0) ? ONE : cfg_half;
    assign ack_d   = wr_ok;
    assign cfg_ack = ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    logic sync_act;
`ifdef CLK_DIV_SYNC_EN
    assign sync_act = sync_req;
`else
    assign sync_act = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] sh_q;
        logic [DIV_W-1:0] sh_d;
        logic [DIV_W-1:0] ah_q;
        logic [DIV_W-1:0] ah_d;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic             en_q;
        logic             en_d;
        logic             clkp_q;
        logic             clkp_d;
        state_e           st_q;
        state_e           st_d;
        logic             sel;
        logic             wrap;

        assign sel  = wr_ok && (ch_idx == 32'(g));
        assign wrap = (cnt_q == (ah_q - ONE));

        always_comb begin
            sh_d   = sel ? wr_half : sh_q;
            en_d   = sel ? cfg_en : en_q;
            ah_d   = ah_q;
            cnt_d  = cnt_q;
            clkp_d = clkp_q;
            st_d   = st_q;
            unique case (st_q)
                PARKED: begin
                    cnt_d  = '0;
                    clkp_d = 1'b0;
                    if (en_d) begin
                        ah_d = sh_d;
                        st_d = RUNNING;
                    end
                end
                RUNNING, STOPPING: begin
                    // boundaries load the pre-write shadow value
                    if (wrap) begin
                        cnt_d  = '0;
                        clkp_d = ~clkp_q;
                        ah_d   = sh_q;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    if (!en_q) begin
                        if (!clkp_q || wrap) begin
                            st_d   = PARKED;
                            cnt_d  = '0;
                            clkp_d = 1'b0;
                        end else begin
                            st_d = STOPPING;
                        end
                    end else begin
                        st_d = RUNNING;
                    end
                end
                default: begin
                    st_d   = PARKED;
                    cnt_d  = '0;
                    clkp_d = 1'b0;
                end
            endcase
            if (sync_act && (st_q != PARKED)) begin
                cnt_d  = '0;
                clkp_d = 1'b0;
                ah_d   = sh_q;
                st_d   = en_q ? RUNNING : PARKED;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sh_q   <= RST_HALF;
                ah_q   <= RST_HALF;
                cnt_q  <= '0;
                en_q   <= 1'b0;
                clkp_q <= 1'b0;
                st_q   <= PARKED;
            end else begin
                sh_q   <= sh_d;
                ah_q   <= ah_d;
                cnt_q  <= cnt_d;
                en_q   <= en_d;
                clkp_q <= clkp_d;
                st_q   <= st_d;
            end
        end

        assign clk_p[g]  = clkp_q;
        assign clk_n[g]  = ~clkp_q;
        assign ch_run[g] = (st_q != PARKED);
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a 4-channel and a 3-channel instance
// share one config bus; a phase-countdown model predicts every cycle.
module tb_clk_div_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_half = '0;
    logic       cfg_en = 1'b0;
    logic       sync_req = 1'b0;

    logic       ack_a;
    logic [3:0] run_a, clkp_a, clkn_a;
    logic       ack_b;
    logic [2:0] run_b, clkp_b, clkn_b;

    always #5 clk = ~clk;

    clk_div_gen #(.NUM_CH(4), .DIV_W(8), .DEFAULT_HALF(1)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_half(cfg_half), .cfg_en(cfg_en), .cfg_ack(ack_a),
        .ch_run(run_a), .clk_p(clkp_a), .clk_n(clkn_a)
`ifdef CLK_DIV_SYNC_EN
        , .sync_req(sync_req)
`endif
    );

    clk_div_gen #(.NUM_CH(3), .DIV_W(8), .DEFAULT_HALF(1)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_half(cfg_half), .cfg_en(cfg_en), .cfg_ack(ack_b),
        .ch_run(run_b), .clk_p(clkp_b), .clk_n(clkn_b)
`ifdef CLK_DIV_SYNC_EN
        , .sync_req(sync_req)
`endif
    );

    typedef struct packed {
        logic       a0;
        logic [3:0] r0;
        logic [3:0] p0;
        logic       a1;
        logic [2:0] r1;
        logic [2:0] p1;
    } exp_t;

    exp_t q[$];
    int n_total = 0;
    int n_pass = 0;

    int unsigned m_sh[2][4];
    int unsigned m_ah[2][4];
    int unsigned m_rem[2][4];
    bit m_en[2][4];
    bit m_run[2][4];
    bit m_p[2][4];
    bit m_ack[2];
    int nch[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        bit any_w, w, nen, old_en;
        int unsigned wh, old_sh;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ack[d] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_sh[d][c] = 1; m_ah[d][c] = 1; m_rem[d][c] = 0;
                    m_en[d][c] = 0; m_run[d][c] = 0; m_p[d][c] = 0;
                end
            end else begin
                any_w = cfg_wr && (int'(cfg_ch) < nch[d]);
                m_ack[d] = any_w;
                wh = (cfg_half == 0) ? 1 : int'(cfg_half);
                for (int c = 0; c < nch[d]; c++) begin
                    w = any_w && (int'(cfg_ch) == c);
                    old_en = m_en[d][c];
                    old_sh = m_sh[d][c];
                    nen = w ? cfg_en : old_en;
                    if (!m_run[d][c]) begin
                        if (nen) begin
                            m_run[d][c] = 1;
                            m_ah[d][c] = w ? wh : old_sh;
                            m_rem[d][c] = m_ah[d][c];
                            m_p[d][c] = 0;
                        end
                    end else if (sync_req) begin
                        m_p[d][c] = 0;
                        m_ah[d][c] = old_sh;
                        m_rem[d][c] = old_sh;
                        if (!old_en) m_run[d][c] = 0;
                    end else if (!old_en && !m_p[d][c]) begin
                        m_run[d][c] = 0;
                    end else if (m_rem[d][c] == 1) begin
                        m_p[d][c] = !m_p[d][c];
                        m_ah[d][c] = old_sh;
                        m_rem[d][c] = old_sh;
                        if (!old_en) m_run[d][c] = 0;
                    end else begin
                        m_rem[d][c] = m_rem[d][c] - 1;
                    end
                    if (w) begin
                        m_sh[d][c] = wh;
                        m_en[d][c] = cfg_en;
                    end
                end
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e = '0;
        e.a0 = m_ack[0];
        e.a1 = m_ack[1];
        for (int c = 0; c < 4; c++) begin
            e.r0[c] = m_run[0][c];
            e.p0[c] = m_p[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            e.r1[c] = m_run[1][c];
            e.p1[c] = m_p[1][c];
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        logic [3:0] n0;
        logic [2:0] n1;
        model_step();
        q.push_back(snap());
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = q.pop_front();
            n0 = ~e.p0;
            n1 = ~e.p1;
            check("ack_a", ack_a, e.a0);
            check("run_a", run_a, e.r0);
            check("clkp_a", clkp_a, e.p0);
            check("clkn_a", clkn_a, n0);
            check("ack_b", ack_b, e.a1);
            check("run_b", run_b, e.r1);
            check("clkp_b", clkp_b, e.p1);
            check("clkn_b", clkn_b, n1);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int ch, input int half, input bit en);
        cfg_wr = 1'b1;
        cfg_ch = 2'(ch);
        cfg_half = 8'(half);
        cfg_en = en;
        tick();
        cfg_wr = 1'b0;
        cfg_en = 1'b0;
    endtask

    task automatic wait_high(input int ch);
        int n;
        n = 0;
        while (clkp_a[ch] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("wait_high_timeout", 0, 1);
    endtask

    initial begin
        nch[0] = 4;
        nch[1] = 3;
        rst = 1'b1;
        ticks(2);
        check("rst_clkp", clkp_a, 4'h0);
        check("rst_clkn", clkn_a, 4'hF);
        check("rst_run", run_a, 4'h0);
        check("rst_ack", ack_a, 1'b0);
        rst = 1'b0;
        ticks(2);

        wr(0, 1, 1'b1);
        check("ack_after_en", ack_a, 1'b1);
        ticks(6);

        wr(1, 3, 1'b1);
        wait_high(1);
        tick();
        wr(1, 5, 1'b1);
        ticks(30);
        wr(1, 0, 1'b1);
        ticks(10);

        wr(2, 4, 1'b1);
        wait_high(2);
        tick();
        wr(2, 4, 1'b0);
        ticks(8);
        wr(2, 4, 1'b1);
        tick();
        wr(2, 4, 1'b0);
        ticks(4);

        wr(3, 2, 1'b1);
        check("bad_ch_ack_b", ack_b, 1'b0);
        check("bad_ch_ack_a", ack_a, 1'b1);
        ticks(3);
        wr(2, 4, 1'b1);
        ticks(7);
        check("all_run", run_a, 4'hF);

        rst = 1'b1;
        tick();
        check("mid_rst_clkp", clkp_a, 4'h0);
        check("mid_rst_run", run_a, 4'h0);
        check("mid_rst_ack", ack_a, 1'b0);
        rst = 1'b0;
        tick();
        wr(1, 1, 1'b1);
        ticks(6);

`ifdef CLK_DIV_SYNC_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr(0, 4, 1'b1);
        ticks(2);
        wr(3, 4, 1'b1);
        ticks(5);
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        check("sync_low", clkp_a, 4'h0);
        ticks(12);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
